// File: rtl/ml_inf_sequencer_if.sv
// Host and model-buffer signals of the inference sequencer.
// slave: sequencer side; master: host plus model environment.
interface ml_inf_sequencer_if #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned INVECWIDTH  = 8,
  parameter int unsigned OUTVECWIDTH = 8
);
  localparam int unsigned InAw  = $clog2(INVECWIDTH);
  localparam int unsigned OutAw = $clog2(OUTVECWIDTH);

  logic              wr_in;
  logic [DATA_W-1:0] in_data;
  logic              in_data_ready;
  logic              rd_out;
  logic [DATA_W-1:0] out_data;
  logic              out_data_valid;
  logic              ml_inf_valid;
  logic              busy;
  logic              err;
  logic              m_wr_en;
  logic [InAw-1:0]   m_wr_addr;
  logic [DATA_W-1:0] m_wr_data;
  logic              m_start;
  logic              m_done;
  logic [OutAw-1:0]  m_rd_addr;
  logic [DATA_W-1:0] m_rd_data;

  modport slave (
    input  wr_in, in_data, in_data_ready, rd_out, m_done, m_rd_data,
    output out_data, out_data_valid, ml_inf_valid, busy, err,
           m_wr_en, m_wr_addr, m_wr_data, m_start, m_rd_addr
  );

  modport master (
    output wr_in, in_data, in_data_ready, rd_out, m_done, m_rd_data,
    input  out_data, out_data_valid, ml_inf_valid, busy, err,
           m_wr_en, m_wr_addr, m_wr_data, m_start, m_rd_addr
  );
endinterface

// File: rtl/ml_inf_sequencer.sv
// Sequences one inference: load input chunks into the model buffer, launch, wait for
// completion (with timeout), then stream the result chunks back to the host.
module ml_inf_sequencer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned INVECWIDTH  = 8,
  parameter int unsigned OUTVECWIDTH = 8,
  parameter int unsigned TIMEOUT     = 20000
) (
  input  logic              clk_100mhz,
  input  logic              sys_rst,
  ml_inf_sequencer_if.slave bus
);
  localparam int unsigned InAw  = $clog2(INVECWIDTH);
  localparam int unsigned OutAw = $clog2(OUTVECWIDTH);
  localparam int unsigned InCw  = $clog2(INVECWIDTH + 1);
  localparam int unsigned OutCw = $clog2(OUTVECWIDTH + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  localparam logic [InCw-1:0]  InFull  = InCw'(INVECWIDTH);
  localparam logic [OutCw-1:0] OutLast = OutCw'(OUTVECWIDTH - 1);
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e              state_q;
  logic [InCw-1:0]     in_cnt_q;
  logic [OutCw-1:0]    out_cnt_q;
  logic [TmoW-1:0]     tmo_cnt_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_data_valid_q;
  logic                ml_inf_valid_q;
  logic                busy_q;
  logic                err_q;
  logic                m_wr_en_q;
  logic [InAw-1:0]     m_wr_addr_q;
  logic [DATA_W-1:0]   m_wr_data_q;
  logic                m_start_q;

  logic                wr_accept;
  logic [InCw-1:0]     in_cnt_next;
  logic                launch;

  // A commit counts a write accepted in the same cycle towards the full vector.
  always_comb begin
    wr_accept   = (state_q == StIdle) && bus.wr_in && (in_cnt_q != InFull);
    in_cnt_next = in_cnt_q + InCw'(wr_accept);
    launch      = (state_q == StIdle) && bus.in_data_ready && (in_cnt_next == InFull);
  end

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      state_q          <= StIdle;
      in_cnt_q         <= '0;
      out_cnt_q        <= '0;
      tmo_cnt_q        <= '0;
      out_data_q       <= '0;
      out_data_valid_q <= 1'b0;
      ml_inf_valid_q   <= 1'b0;
      busy_q           <= 1'b0;
      err_q            <= 1'b0;
      m_wr_en_q        <= 1'b0;
      m_wr_addr_q      <= '0;
      m_wr_data_q      <= '0;
      m_start_q        <= 1'b0;
    end else begin
      m_wr_en_q        <= 1'b0;
      m_start_q        <= 1'b0;
      out_data_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_accept) begin
            m_wr_en_q   <= 1'b1;
            m_wr_addr_q <= in_cnt_q[InAw-1:0];
            m_wr_data_q <= bus.in_data;
          end else if (bus.wr_in) begin
            err_q <= 1'b1;
          end
          in_cnt_q <= in_cnt_next;
          if (launch) begin
            m_start_q <= 1'b1;
            busy_q    <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= StRun;
          end else if (bus.in_data_ready) begin
            err_q <= 1'b1;
          end
        end
        StRun: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          if (bus.wr_in || bus.in_data_ready) err_q <= 1'b1;
          // Completion takes priority over a timeout expiring in the same cycle.
          if (bus.m_done) begin
            busy_q         <= 1'b0;
            ml_inf_valid_q <= 1'b1;
            out_cnt_q      <= '0;
            state_q        <= StDrain;
          end else if (tmo_cnt_q == TmoLast) begin
            busy_q         <= 1'b0;
            err_q          <= 1'b1;
            in_cnt_q       <= '0;
            ml_inf_valid_q <= 1'b0;
            state_q        <= StIdle;
          end
        end
        StDrain: begin
          if (bus.wr_in || bus.in_data_ready) err_q <= 1'b1;
          if (bus.rd_out) begin
            out_data_q       <= bus.m_rd_data;
            out_data_valid_q <= 1'b1;
            out_cnt_q        <= out_cnt_q + 1'b1;
            if (out_cnt_q == OutLast) begin
              ml_inf_valid_q <= 1'b0;
              in_cnt_q       <= '0;
              state_q        <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m_rd_addr      = out_cnt_q[OutAw-1:0];
  assign bus.out_data       = out_data_q;
  assign bus.out_data_valid = out_data_valid_q;
  assign bus.ml_inf_valid   = ml_inf_valid_q;
  assign bus.busy           = busy_q;
  assign bus.err            = err_q;
  assign bus.m_wr_en        = m_wr_en_q;
  assign bus.m_wr_addr      = m_wr_addr_q;
  assign bus.m_wr_data      = m_wr_data_q;
  assign bus.m_start        = m_start_q;
endmodule

// File: tb/tb_ml_inf_sequencer.sv
// Randomised bench for ml_inf_sequencer with a model stub (reverse, bias, ReLU) and a
// queue-based reference of the chunks the host expects to have been accepted.
module tb_ml_inf_sequencer;
  localparam int DW   = 8;
  localparam int INW  = 8;
  localparam int OUTW = 8;
  localparam int TMO  = 300;

  logic clk;
  logic sys_rst;

  ml_inf_sequencer_if #(.DATA_W(DW), .INVECWIDTH(INW), .OUTVECWIDTH(OUTW)) bus ();

  ml_inf_sequencer #(
    .DATA_W     (DW),
    .INVECWIDTH (INW),
    .OUTVECWIDTH(OUTW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_100mhz(clk),
    .sys_rst   (sys_rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  acc[$];
  logic [7:0]  got_q[$];
  bit          exp_err;
  logic [7:0]  last_out;
  int          stub_lat;
  bit          stub_hang;
  int          n_busy;
  logic [7:0]  exp38 [8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd3, 8'd5, 8'd7};

  // Model function: out[j] = ReLU(in[N-1-j] + (j+1)), saturated to 127.
  function automatic logic [7:0] golden(input logic [7:0] x, input int j);
    int v;
    v = int'($signed(x)) + j + 1;
    if (v < 0) v = 0;
    if (v > 127) v = 127;
    return 8'(v);
  endfunction

  // Model stub: captures the input buffer, fires m_done stub_lat+1 cycles after m_start.
  logic [7:0] mem [INW];
  logic [7:0] res [OUTW];
  int         cd;
  assign bus.m_rd_data = res[bus.m_rd_addr];

  always @(posedge clk) begin
    bus.m_done <= 1'b0;
    if (sys_rst) begin
      cd <= 0;
    end else if (bus.m_start && !stub_hang) begin
      cd <= stub_lat;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        bus.m_done <= 1'b1;
        for (int j = 0; j < OUTW; j++) res[j] <= golden(mem[OUTW-1-j], j);
      end
    end
    if (bus.m_wr_en) mem[bus.m_wr_addr] <= bus.m_wr_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit noisy);
    sys_rst = 1'b1;
    bus.wr_in = noisy; bus.in_data_ready = noisy; bus.rd_out = noisy; bus.in_data = 8'hA5;
    tick();
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_out_valid", bus.out_data_valid, 0);
    check_eq("rst_inf_valid", bus.ml_inf_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_err", bus.err, 0);
    check_eq("rst_wr_en", bus.m_wr_en, 0);
    check_eq("rst_start", bus.m_start, 0);
    sys_rst = 1'b0;
    bus.wr_in = 0; bus.in_data_ready = 0; bus.rd_out = 0; bus.in_data = '0;
    exp_err = 0; acc.delete(); last_out = '0;
  endtask

  // One IDLE cycle with an optional write and/or commit.
  task automatic step_in(input bit wr, input logic [7:0] d, input bit cm);
    bus.wr_in = wr; bus.in_data = d; bus.in_data_ready = cm;
    tick();
    bus.wr_in = 0; bus.in_data_ready = 0;
    if (wr) begin
      if (acc.size() < INW) begin
        acc.push_back(d);
        check_eq("wr_en", bus.m_wr_en, 1);
        check_eq("wr_addr", bus.m_wr_addr, acc.size() - 1);
        check_eq("wr_data", bus.m_wr_data, d);
      end else begin
        exp_err = 1;
        check_eq("wr_drop", bus.m_wr_en, 0);
      end
    end
    if (cm) begin
      if (acc.size() == INW) begin
        check_eq("start", bus.m_start, 1);
        check_eq("busy_on", bus.busy, 1);
      end else begin
        exp_err = 1;
        check_eq("early_commit", bus.m_start, 0);
      end
    end
    check_eq("err_in", bus.err, exp_err);
  endtask

  task automatic load_random(input int n, input bit commit_last);
    for (int i = 0; i < n; i++) step_in(1, 8'($urandom), commit_last && (i == n - 1));
  endtask

  task automatic wait_run(input bit inject, input bit exp_tmo);
    n_busy = 1;
    for (int i = 0; i < TMO + 20; i++) begin
      bit inj;
      inj = inject && ($urandom_range(0, 15) == 0);
      if (inj) begin
        if ($urandom_range(0, 1) != 0) bus.wr_in = 1; else bus.in_data_ready = 1;
        exp_err = 1;
      end
      tick();
      bus.wr_in = 0; bus.in_data_ready = 0;
      if (i == 0) check_eq("start_pulse", bus.m_start, 0);
      if (inj) check_eq("run_drop", bus.m_wr_en, 0);
      if (!bus.busy) break;
      n_busy++;
    end
    check_eq("run_exit", bus.busy, 0);
    if (exp_tmo) begin
      exp_err = 1;
      acc.delete();
      check_eq("tmo_len", n_busy, TMO);
      check_eq("tmo_inf_valid", bus.ml_inf_valid, 0);
    end else begin
      check_eq("run_len", n_busy, stub_lat + 2);
      check_eq("inf_valid", bus.ml_inf_valid, 1);
    end
    check_eq("err_run", bus.err, exp_err);
  endtask

  // mode 0: rd_out held; 1: alternate 1,0,1..; 2: random gaps.
  task automatic read_drain(input int mode, input bit inject, input int n_reads);
    int j;
    j = 0;
    got_q.delete();
    for (int c = 0; c < 200 && j < n_reads; c++) begin
      bit rd;
      bit inj;
      rd  = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 2) != 0);
      inj = !rd && inject && ($urandom_range(0, 3) == 0);
      if (inj) begin
        bus.wr_in = 1;
        exp_err = 1;
      end
      bus.rd_out = rd;
      tick();
      bus.rd_out = 0; bus.wr_in = 0;
      if (inj) check_eq("drain_drop", bus.m_wr_en, 0);
      if (rd) begin
        last_out = golden(acc[INW-1-j], j);
        got_q.push_back(bus.out_data);
        j++;
        check_eq("out_valid", bus.out_data_valid, 1);
        check_eq("out_data", bus.out_data, last_out);
        check_eq("inf_valid_rd", bus.ml_inf_valid, (j < OUTW) ? 1 : 0);
      end else begin
        check_eq("gap_valid", bus.out_data_valid, 0);
        check_eq("gap_hold", bus.out_data, last_out);
        check_eq("inf_valid_gap", bus.ml_inf_valid, 1);
      end
    end
    check_eq("drain_count", j, n_reads);
    check_eq("err_drain", bus.err, exp_err);
    if (j == OUTW) acc.delete();
  endtask

  task automatic idle_read();
    bus.rd_out = 1;
    tick();
    bus.rd_out = 0;
    check_eq("idle_rd_valid", bus.out_data_valid, 0);
    check_eq("idle_rd_hold", bus.out_data, last_out);
    check_eq("idle_rd_err", bus.err, exp_err);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1;
    bus.wr_in = 0; bus.in_data = '0; bus.in_data_ready = 0; bus.rd_out = 0;
    stub_hang = 0;
    stub_lat = 99;
    do_reset(1);

    // Load -1..-8, m_done 100 cycles after m_start, stream the ReLU result.
    for (int i = 0; i < INW; i++) step_in(1, 8'(-(i + 1)), 0);
    step_in(0, '0, 1);
    wait_run(0, 0);
    read_drain(0, 0, OUTW);
    for (int k = 0; k < OUTW; k++) check_eq("relu_vec", got_q[k], exp38[k]);
    check_eq("err_clean", bus.err, 0);
    idle_read();

    // rd_out toggling 1,0,1 must not skip chunks.
    stub_lat = 5;
    load_random(INW, 0);
    step_in(0, '0, 1);
    wait_run(0, 0);
    read_drain(1, 0, OUTW);

    // 9th write dropped; commit still launches with the first 8.
    do_reset(0);
    load_random(INW + 1, 0);
    check_eq("overflow_err", bus.err, 1);
    step_in(0, '0, 1);
    wait_run(0, 0);
    read_drain(0, 0, OUTW);

    // Commit after 5 chunks ignored; 3 more plus commit launches.
    do_reset(0);
    load_random(5, 0);
    step_in(0, '0, 1);
    load_random(3, 0);
    step_in(0, '0, 1);
    wait_run(0, 0);
    read_drain(0, 0, OUTW);

    // Model never completes: busy for exactly TIMEOUT cycles.
    do_reset(0);
    stub_hang = 1;
    load_random(INW, 1);
    wait_run(0, 1);
    stub_hang = 0;

    // m_done one cycle after the timeout lands in IDLE and is ignored.
    stub_lat = TMO - 1;
    load_random(INW, 1);
    wait_run(0, 1);
    repeat (3) tick();
    check_eq("late_done_ignored", bus.ml_inf_valid, 0);
    check_eq("late_done_busy", bus.busy, 0);

    // m_done in the final timeout cycle wins.
    do_reset(0);
    stub_lat = TMO - 2;
    load_random(INW, 1);
    wait_run(0, 0);
    read_drain(2, 0, OUTW);

    // Reset mid-drain, then a fresh full sequence.
    stub_lat = 20;
    load_random(INW, 0);
    step_in(0, '0, 1);
    wait_run(0, 0);
    read_drain(0, 0, 3);
    do_reset(0);
    load_random(INW, 0);
    step_in(0, '0, 1);
    wait_run(0, 0);
    read_drain(0, 0, OUTW);
    check_eq("after_rst_err", bus.err, 0);

    // Randomised inferences with protocol noise.
    for (int it = 0; it < 10; it++) begin
      bit early;
      bit extra;
      bit combine;
      if ($urandom_range(0, 1) != 0) do_reset($urandom_range(0, 1) != 0);
      stub_lat = $urandom_range(1, 150);
      early    = ($urandom_range(0, 3) == 0);
      extra    = ($urandom_range(0, 3) == 0);
      combine  = !extra && ($urandom_range(0, 1) != 0);
      if (early) begin
        load_random(5, 0);
        step_in(0, '0, 1);
      end
      load_random(early ? 3 : INW, combine);
      if (extra) step_in(1, 8'($urandom), 0);
      if (!combine) step_in(0, '0, 1);
      wait_run(1, 0);
      read_drain(2, 1, OUTW);
      if ($urandom_range(0, 1) != 0) idle_read();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
